ysyx_25020037_ifu: RTL and testbench



---
 rtl/ysyx_25020037_ifu_pkg.sv | 29 ++
 rtl/ysyx_25020037_ifu.sv | 135 +++++++++++++
 tb/tb_ysyx_25020037_ifu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_ifu_pkg.sv
// ============================================================================
// Module      : ysyx_25020037_ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25020037_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    localparam int          FU_TO_DU_BUS_WD = 64;
    localparam logic [31:0] IFU_RESET_PC    = 32'h3000_0000;
    localparam logic [31:0] IFU_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [1:0]  IFU_RESP_OKAY   = 2'b00;

    // Redirect targets are word-aligned; the low two bits are discarded.
    function automatic logic [31:0] ifu_align(input logic [31:0] addr);
        return addr & IFU_ALIGN_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25020037_ifu.sv
// ============================================================================
// Module      : ysyx_25020037_ifu
// Description : Instruction fetch unit with one outstanding read, redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25020037_ifu
    import ysyx_25020037_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst,

    output logic                       ifu_valid,
    input  logic                       idu_ready,
    output logic [FU_TO_DU_BUS_WD-1:0] fu_to_du_bus,
    output logic                       ifu_access_fault,

    input  logic                       exu_dnpc_valid,
    input  logic [31:0]                exu_dnpc,

    output logic                       ifu_arvalid,
    output logic [31:0]                ifu_araddr,
    input  logic                       ifu_arready,
    input  logic                       ifu_rvalid,
    input  logic [31:0]                ifu_rdata,
    input  logic [1:0]                 ifu_rresp,
    output logic                       ifu_rready
);

    ifu_state_e                 state_q, state_d;
    logic [31:0]                pc_q, pc_d;
    logic                       redir_pend_q, redir_pend_d;
    logic [31:0]                redir_pc_q, redir_pc_d;
    logic [FU_TO_DU_BUS_WD-1:0] bus_q, bus_d;
    logic                       fault_q, fault_d;

    logic [31:0]                redir_tgt;
    logic                       resp_err;

    assign redir_tgt = ifu_align(exu_dnpc);
    assign resp_err  = (ifu_rresp != IFU_RESP_OKAY);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        bus_d        = bus_q;
        fault_d      = fault_q;

        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_ADDR;
                if (exu_dnpc_valid) begin
                    pc_d = redir_tgt;
                end
            end

            IFU_ADDR: begin
                if (exu_dnpc_valid) begin
                    redir_pend_d = 1'b1;
                    redir_pc_d   = redir_tgt;
                end
                if (ifu_arready) begin
                    state_d = IFU_DATA;
                end
            end

            IFU_DATA: begin
                if (exu_dnpc_valid) begin
                    redir_pend_d = 1'b1;
                    redir_pc_d   = redir_tgt;
                end
                if (ifu_rvalid) begin
                    // A redirect landing with the response still squashes it.
                    if (redir_pend_q || exu_dnpc_valid) begin
                        state_d      = IFU_ADDR;
                        pc_d         = exu_dnpc_valid ? redir_tgt : redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        state_d = IFU_HOLD;
                        bus_d   = {pc_q, (resp_err ? 32'h0 : ifu_rdata)};
                        fault_d = resp_err;
                    end
                end
            end

            IFU_HOLD: begin
                if (exu_dnpc_valid) begin
                    state_d = IFU_ADDR;
                    pc_d    = redir_tgt;
                end else if (idu_ready) begin
                    state_d = IFU_ADDR;
                    pc_d    = pc_q + 32'd4;
                end
            end

            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IFU_IDLE;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'h0;
            bus_q        <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            bus_q        <= bus_d;
            fault_q      <= fault_d;
        end
    end

    // Handshake outputs come straight from the state register.
    assign ifu_arvalid      = (state_q == IFU_ADDR);
    assign ifu_rready       = (state_q == IFU_DATA);
    assign ifu_valid        = (state_q == IFU_HOLD);
    assign ifu_araddr       = pc_q;
    assign fu_to_du_bus     = bus_q;
    assign ifu_access_fault = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25020037_ifu.sv
// ============================================================================
// Module      : tb_ysyx_25020037_ifu
// Description : Directed self-checking bench for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25020037_ifu;

    logic        clk;
    logic        rst;
    logic        ifu_valid;
    logic        idu_ready;
    logic [63:0] fu_to_du_bus;
    logic        ifu_access_fault;
    logic        exu_dnpc_valid;
    logic [31:0] exu_dnpc;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic        ifu_arready;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rready;

    int total;
    int bad;

    // Slave model controls
    logic        arready_en;
    int          rdelay;
    logic [31:0] fault_addr;
    logic        s_busy;
    int          s_cnt;
    logic [31:0] s_addr;

    ysyx_25020037_ifu #(.RESET_PC(32'h3000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_valid        (ifu_valid),
        .idu_ready        (idu_ready),
        .fu_to_du_bus     (fu_to_du_bus),
        .ifu_access_fault (ifu_access_fault),
        .exu_dnpc_valid   (exu_dnpc_valid),
        .exu_dnpc         (exu_dnpc),
        .ifu_arvalid      (ifu_arvalid),
        .ifu_araddr       (ifu_araddr),
        .ifu_arready      (ifu_arready),
        .ifu_rvalid       (ifu_rvalid),
        .ifu_rdata        (ifu_rdata),
        .ifu_rresp        (ifu_rresp),
        .ifu_rready       (ifu_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h3000_0000) return 32'h0000_0413;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign ifu_arready = arready_en;
    assign ifu_rvalid  = s_busy && (s_cnt == 0);
    assign ifu_rdata   = mem_word(s_addr);
    assign ifu_rresp   = (s_addr == fault_addr) ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            s_busy <= 1'b0;
            s_cnt  <= 0;
            s_addr <= 32'h0;
        end else if (s_busy) begin
            if (s_cnt != 0) s_cnt <= s_cnt - 1;
            else if (ifu_rready) s_busy <= 1'b0;
        end else if (ifu_arvalid && ifu_arready) begin
            s_busy <= 1'b1;
            s_cnt  <= rdelay;
            s_addr <= ifu_araddr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!ifu_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", {63'd0, ifu_valid}, 64'd1);
    endtask

    // Waits for the next address phase; ifu_valid must stay low meanwhile.
    task automatic wait_arvalid_no_valid(input string tag, input int budget);
        int  n = 0;
        logic seen = 1'b0;
        while (!ifu_arvalid && n < budget) begin
            if (ifu_valid) seen = 1'b1;
            tick();
            n++;
        end
        if (ifu_valid) seen = 1'b1;
        chk({tag, "_arvalid"}, {63'd0, ifu_arvalid}, 64'd1);
        chk({tag, "_no_valid"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        idu_ready      = 1'b0;
        exu_dnpc_valid = 1'b0;
        exu_dnpc       = 32'h0;
        arready_en     = 1'b1;
        rdelay         = 0;
        fault_addr     = 32'hFFFF_FFF0;

        tick(); tick(); tick();
        chk("rst_valid",   {63'd0, ifu_valid},        64'd0);
        chk("rst_arvalid", {63'd0, ifu_arvalid},      64'd0);
        chk("rst_rready",  {63'd0, ifu_rready},       64'd0);
        chk("rst_bus",     fu_to_du_bus,              64'd0);
        chk("rst_fault",   {63'd0, ifu_access_fault}, 64'd0);

        // Cycle 0 after reset release: still IDLE.
        rst = 1'b0;
        chk("c0_arvalid", {63'd0, ifu_arvalid}, 64'd0);
        tick();
        chk("c1_arvalid", {63'd0, ifu_arvalid}, 64'd1);
        chk("c1_araddr",  {32'd0, ifu_araddr},  64'h3000_0000);
        tick();
        chk("c2_rready",  {63'd0, ifu_rready},  64'd1);
        chk("c2_valid",   {63'd0, ifu_valid},   64'd0);
        tick();
        chk("c3_valid",   {63'd0, ifu_valid},   64'd1);
        chk("c3_bus",     fu_to_du_bus,         64'h3000_0000_0000_0413);

        // Decode stalls for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid",   {63'd0, ifu_valid},   64'd1);
            chk("stall_bus",     fu_to_du_bus,         64'h3000_0000_0000_0413);
            chk("stall_arvalid", {63'd0, ifu_arvalid}, 64'd0);
        end
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        chk("seq_arvalid", {63'd0, ifu_arvalid}, 64'd1);
        chk("seq_araddr",  {32'd0, ifu_araddr},  64'h3000_0004);
        chk("seq_valid",   {63'd0, ifu_valid},   64'd0);

        // Redirect during DATA with a slow response.
        rdelay = 4;
        tick();
        chk("rd_rready", {63'd0, ifu_rready}, 64'd1);
        exu_dnpc_valid = 1'b1;
        exu_dnpc       = 32'h3000_0103;
        tick();
        exu_dnpc_valid = 1'b0;
        rdelay         = 0;
        wait_arvalid_no_valid("rd", 20);
        chk("rd_araddr",  {32'd0, ifu_araddr}, 64'h3000_0100);
        chk("rd_drained", {63'd0, s_busy},     64'd0);
        wait_valid(10);
        chk("rd_bus", fu_to_du_bus, {32'h3000_0100, mem_word(32'h3000_0100)});

        // Redirect coinciding with a HOLD handshake.
        idu_ready      = 1'b1;
        exu_dnpc_valid = 1'b1;
        exu_dnpc       = 32'h3000_0200;
        tick();
        idu_ready      = 1'b0;
        exu_dnpc_valid = 1'b0;
        chk("hr_valid",   {63'd0, ifu_valid},   64'd0);
        chk("hr_arvalid", {63'd0, ifu_arvalid}, 64'd1);
        chk("hr_araddr",  {32'd0, ifu_araddr},  64'h3000_0200);

        // Two redirects during one outstanding read.
        rdelay = 6;
        tick();
        chk("dr_rready", {63'd0, ifu_rready}, 64'd1);
        exu_dnpc_valid = 1'b1;
        exu_dnpc       = 32'h3000_0400;
        tick();
        exu_dnpc_valid = 1'b0;
        tick();
        exu_dnpc_valid = 1'b1;
        exu_dnpc       = 32'h3000_0800;
        tick();
        exu_dnpc_valid = 1'b0;
        rdelay         = 0;
        wait_arvalid_no_valid("dr", 20);
        chk("dr_araddr", {32'd0, ifu_araddr}, 64'h3000_0800);

        // Error response on the following fetch.
        fault_addr = 32'h3000_0804;
        wait_valid(10);
        chk("f0_bus",   fu_to_du_bus,              {32'h3000_0800, mem_word(32'h3000_0800)});
        chk("f0_fault", {63'd0, ifu_access_fault}, 64'd0);
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        wait_valid(10);
        chk("f1_bus",   fu_to_du_bus,              64'h3000_0804_0000_0000);
        chk("f1_fault", {63'd0, ifu_access_fault}, 64'd1);

        // Address held until arready.
        idu_ready  = 1'b1;
        arready_en = 1'b0;
        tick();
        idu_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ah_arvalid", {63'd0, ifu_arvalid}, 64'd1);
            chk("ah_araddr",  {32'd0, ifu_araddr},  64'h3000_0808);
            tick();
        end
        arready_en = 1'b1;
        wait_valid(10);
        chk("ah_bus",   fu_to_du_bus,              {32'h3000_0808, mem_word(32'h3000_0808)});
        chk("ah_fault", {63'd0, ifu_access_fault}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
